// File: rtl/countdown_start_ctrl.sv
// Start controller for the 5-bit countdown counter: debounces the push-button and
// drives the counter's level start/ready handshake with auto-repeat, abort and ack timeout.
module countdown_start_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16,
  parameter int RUNS_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  input  logic              repeat_en,
  input  logic              abort,
  input  logic              ready,
  output logic              start,
  output logic              busy,
  output logic              done_pulse,
  output logic              err,
  output logic [RUNS_W-1:0] runs
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_GAP,
    S_ERROR
  } state_t;

  localparam logic [7:0]        DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]        TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [RUNS_W-1:0] RUNS_MAX = '1;

  logic       sync1, sync2;
  logic       db_level, db_prev;
  logic [7:0] db_cnt;
  logic [7:0] to_cnt;
  logic       press;
  state_t     state, state_nxt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // The debounced level only follows sync2 after DEBOUNCE_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  assign press = db_level & ~db_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (press && ready) state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (!ready)            state_nxt = S_RUN;
        else if (to_cnt == TO_LAST) state_nxt = S_ERROR;
      end
      S_RUN: begin
        if (abort)      state_nxt = S_IDLE;
        else if (ready) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = (repeat_en && !abort) ? S_GAP : S_IDLE;
      S_GAP:    state_nxt = (repeat_en && !abort) ? S_LAUNCH : S_IDLE;
      S_ERROR:  if (press) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Ack timeout counts cycles spent in LAUNCH; any exit clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == S_LAUNCH && state_nxt == S_LAUNCH) begin
      to_cnt <= to_cnt + 8'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  // A completion is counted on the RUN->DONE edge so runs is already updated during done_pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runs <= '0;
    end else if (state == S_RUN && state_nxt == S_DONE && runs != RUNS_MAX) begin
      runs <= runs + 1'b1;
    end
  end

  assign start      = (state == S_LAUNCH) || (state == S_RUN);
  assign busy       = (state == S_LAUNCH) || (state == S_RUN) || (state == S_GAP);
  assign done_pulse = (state == S_DONE);
  assign err        = (state == S_ERROR);

endmodule

// File: tb/tb_countdown_start_ctrl.sv
// Bench for countdown_start_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural model of the button/handshake rules.
module tb_countdown_start_ctrl;

  localparam int DB   = 4;
  localparam int TO   = 16;
  localparam int RW   = 8;
  localparam int RMAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_in = 1'b0;
  logic          repeat_en = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b1;
  logic          start, busy, done_pulse, err;
  logic [RW-1:0] runs;

  int n_checks = 0;
  int n_errors = 0;

  countdown_start_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .ACK_TIMEOUT    (TO),
    .RUNS_W         (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .abort     (abort),
    .ready     (ready),
    .start     (start),
    .busy      (busy),
    .done_pulse(done_pulse),
    .err       (err),
    .runs      (runs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: debounce as "last DB observed samples all disagree with the level",
  // handshake as a phase walk driven straight from the written rules.
  typedef enum {M_IDLE, M_LAUNCH, M_RUN, M_DONE, M_GAP, M_ERROR} mph_t;
  mph_t m_ph = M_IDLE;
  int   m_wait = 0;
  int   m_runs = 0;
  bit   m_level = 0;
  bit   m_press = 0;
  bit   raw_q[$];
  bit   hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = M_IDLE; m_wait = 0; m_runs = 0; m_level = 0; m_press = 0;
      raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
      hist.delete();
    end else begin
      bit s;
      bit all_diff;
      case (m_ph)
        M_IDLE:   if (m_press && ready) begin m_ph = M_LAUNCH; m_wait = 0; end
        M_LAUNCH: begin
          m_wait++;
          if (abort)             m_ph = M_IDLE;
          else if (!ready)       m_ph = M_RUN;
          else if (m_wait >= TO) m_ph = M_ERROR;
        end
        M_RUN: begin
          if (abort) m_ph = M_IDLE;
          else if (ready) begin
            m_ph   = M_DONE;
            m_runs = (m_runs + 1 > RMAX) ? RMAX : m_runs + 1;
          end
        end
        M_DONE:  m_ph = (repeat_en && !abort) ? M_GAP : M_IDLE;
        M_GAP: begin
          if (repeat_en && !abort) begin m_ph = M_LAUNCH; m_wait = 0; end
          else m_ph = M_IDLE;
        end
        M_ERROR: if (m_press) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
      s = raw_q.pop_front();
      raw_q.push_back(btn_in);
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      all_diff = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
      m_press = 1'b0;
      if (all_diff) begin
        m_level = !m_level;
        m_press = m_level;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("model_start", start,      (m_ph == M_LAUNCH || m_ph == M_RUN));
      check("model_busy",  busy,       (m_ph == M_LAUNCH || m_ph == M_RUN || m_ph == M_GAP));
      check("model_done",  done_pulse, (m_ph == M_DONE));
      check("model_err",   err,        (m_ph == M_ERROR));
      check("model_runs",  runs,       m_runs);
    end
  end

  // Counter emulation: drops ready e_delay_cfg cycles after seeing start, counts e_len_cfg
  // cycles, raises ready, then waits for start to go low. e_dead keeps ready stuck high.
  bit e_dead = 0;
  int e_delay_cfg = 0;
  int e_len_cfg = 8;
  int e_cnt = 0;
  int e_delay = 0;
  bit e_need_low = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      ready = 1'b1; e_cnt = 0; e_need_low = 0; e_delay = e_delay_cfg;
    end else if (e_cnt > 0) begin
      e_cnt--;
      if (e_cnt == 0) begin ready = 1'b1; e_need_low = 1; end
    end else if (e_need_low) begin
      if (!start) e_need_low = 0;
      e_delay = e_delay_cfg;
    end else if (!start || e_dead) begin
      e_delay = e_delay_cfg;
    end else if (e_delay > 0) begin
      e_delay--;
    end else begin
      ready = 1'b0;
      e_cnt = e_len_cfg;
    end
  end

  int n_launch = 0;
  int n_done_tot = 0;
  bit start_d = 0;
  always @(negedge clk) begin
    if (start && !start_d) n_launch++;
    if (done_pulse) n_done_tot++;
    start_d = start;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic measure_latency(input string name);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!start && lat < 40);
    check(name, lat, DB + 3);
  endtask

  task automatic wait_done(input string name, input int limit);
    int c;
    c = 0;
    while (!done_pulse && c < limit) begin tick(); c++; end
    check(name, done_pulse, 1);
  endtask

  task automatic release_btn();
    btn_in = 1'b0;
    tick(DB + 6);
  endtask

  initial begin
    int hi, r0, d0, l0, dones, rises, low_len, hold;
    bit started, seen_low, prev_start;

    // Reset state
    tick(3);
    check("rst_start", start, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done_pulse, 0);
    check("rst_err",   err, 0);
    check("rst_runs",  runs, 0);
    rst = 1'b1;
    chk_en = 1;
    tick(2);

    // Clean press: 32-cycle countdown
    e_len_cfg = 32;
    btn_in = 1'b1;
    measure_latency("clean_latency");
    wait_done("clean_done_seen", 80);
    check("clean_runs", runs, 1);
    check("clean_start_low", start, 0);
    check("clean_busy_low", busy, 0);
    tick();
    check("clean_done_one_cycle", done_pulse, 0);
    release_btn();

    // Bounce then stable high
    e_len_cfg = 8;
    l0 = n_launch;
    for (int i = 0; i < 20; i++) begin
      btn_in = ((i / 2) % 2) == 0;
      tick();
    end
    check("bounce_no_launch", n_launch - l0, 0);
    btn_in = 1'b1;
    measure_latency("bounce_latency");
    wait_done("bounce_done_seen", 60);
    tick(10);
    check("bounce_one_launch", n_launch - l0, 1);
    release_btn();

    // Auto-repeat for three runs
    r0 = runs; l0 = n_launch;
    repeat_en = 1'b1;
    btn_in = 1'b1;
    dones = 0; low_len = 0; started = 0; prev_start = 0; rises = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done_pulse) dones++;
      if (dones == 2 && start && !ready) repeat_en = 1'b0;
      if (start && !prev_start) begin
        rises++;
        if (started) check("repeat_gap_len", low_len, 2);
        started = 1;
      end
      low_len = start ? 0 : low_len + 1;
      prev_start = start;
    end
    check("repeat_runs", runs, r0 + 3);
    check("repeat_launches", rises, 3);
    check("repeat_idle_start", start, 0);
    check("repeat_idle_busy", busy, 0);
    release_btn();

    // Ack timeout
    e_dead = 1;
    btn_in = 1'b1;
    measure_latency("timeout_latency");
    hi = 0;
    while (start && hi < 100) begin tick(); hi++; end
    check("timeout_len", hi, TO);
    check("timeout_err", err, 1);
    check("timeout_start", start, 0);
    release_btn();
    e_dead = 0;
    btn_in = 1'b1;
    tick(DB + 6);
    check("err_clear_err", err, 0);
    check("err_clear_start", start, 0);
    check("err_clear_busy", busy, 0);
    release_btn();

    // Abort mid-run
    e_len_cfg = 32;
    btn_in = 1'b1;
    measure_latency("abort_latency");
    hi = 0;
    while (ready && hi < 40) begin tick(); hi++; end
    tick(21);
    r0 = runs; d0 = n_done_tot;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_start", start, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done_pulse, 0);
    check("abort_runs", runs, r0);
    tick(30);
    check("abort_no_done_later", n_done_tot - d0, 0);
    release_btn();

    // Abort coincident with ready rising
    e_len_cfg = 6;
    btn_in = 1'b1;
    seen_low = 0; hold = 0;
    while (hold < 80 && !(seen_low && start && ready)) begin
      tick(); hold++;
      if (!ready) seen_low = 1;
    end
    check("coinc_reached", seen_low && start && ready, 1);
    r0 = runs; d0 = n_done_tot;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("coinc_done", done_pulse, 0);
    check("coinc_start", start, 0);
    check("coinc_runs", runs, r0);
    tick(3);
    check("coinc_no_done_later", n_done_tot - d0, 0);
    release_btn();

    // Reset mid-run
    e_len_cfg = 32;
    btn_in = 1'b1;
    measure_latency("rstmid_latency");
    hi = 0;
    while (ready && hi < 40) begin tick(); hi++; end
    tick(11);
    #2 rst = 1'b0;
    #1;
    check("rstmid_start_async", start, 0);
    check("rstmid_runs", runs, 0);
    check("rstmid_busy", busy, 0);
    btn_in = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(DB + 6);
    check("rstmid_idle_busy", busy, 0);
    e_len_cfg = 5;
    btn_in = 1'b1;
    measure_latency("rstmid_relaunch_latency");
    wait_done("rstmid_done_seen", 40);
    check("rstmid_runs_after", runs, 1);
    release_btn();

    // Random stimulus against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        btn_in = $urandom_range(0, 1);
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      abort = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) repeat_en = ~repeat_en;
      if ($urandom_range(0, 199) == 0) e_dead = ~e_dead;
      if (!start) e_delay_cfg = $urandom_range(0, 20);
      e_len_cfg = $urandom_range(1, 10);
      tick();
    end
    abort = 1'b0; repeat_en = 1'b0; e_dead = 0; e_delay_cfg = 0; btn_in = 1'b0;
    tick(30);

    // Saturation of the run counter
    #2 rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    e_len_cfg = 2;
    repeat_en = 1'b1;
    btn_in = 1'b1;
    dones = 0;
    for (int c = 0; c < 4000 && dones < RMAX + 3; c++) begin
      tick();
      if (done_pulse) dones++;
    end
    check("sat_dones", dones, RMAX + 3);
    check("sat_runs", runs, RMAX);
    repeat_en = 1'b0;
    btn_in = 1'b0;
    tick(20);
    check("sat_runs_hold", runs, RMAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
